// File: rtl/cram_access_arb_pkg.sv
// Shared types for the CRAM access arbiter: FSM state encoding, grant
// codes, and the forward/backward token structs used by the sequencers.
package cram_access_arb_pkg;

    // Data width carried by the forward token; the arbiter's WIDTH_DATA
    // is expected to match it.
    localparam int TK_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_ST = 2'd1,
        GNT_LD = 2'd2,
        DRAIN  = 2'd3
    } cram_arb_state_t;

    localparam logic [1:0] ARB_GNT_ST = 2'b01;
    localparam logic [1:0] ARB_GNT_LD = 2'b10;

    // Forward token: r marks the release (last word) of a store block.
    typedef struct packed {
        logic                 r;
        logic [TK_DATA_W-1:0] d;
    } FTk_t;

    // Backward token: n = stall/nack, t = session terminated, a reserved.
    typedef struct packed {
        logic a;
        logic t;
        logic n;
    } BTk_t;

endpackage

// File: rtl/cram_arb_watchdog.sv
// Idle watchdog for the CRAM arbiter: counts consecutive idle cycles of
// the current grant owner and flags expiry on the IDLE_TIMEOUT-th one.
module cram_arb_watchdog #(
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    logic [7:0] r_count;

    // Idle-cycle counter; any activity or loss of grant clears it
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Expiry only on an idle cycle, so a request can never coincide with it
    assign o_expire = i_inc && (r_count == 8'(IDLE_TIMEOUT - 1));

endmodule

// File: rtl/cram_access_arb.sv
// Session arbiter sharing one single-port CRAM between a store and a load
// sequencer. Grants whole sessions, round-robin on ties, nacks the loser,
// and revokes a grant whose owner has gone idle.
// Build option: define CRAM_ARB_FIXED_PRIO_EN to make store win every tie
// (no last-owner history register).
module cram_access_arb
    import cram_access_arb_pkg::*;
#(
    parameter int WIDTH_DATA   = 32,
    parameter int WIDTH_ADDR   = 8,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_St_Req,
    input  logic [WIDTH_ADDR-1:0] I_St_Addr,
    input  FTk_t                  I_St_FTk,
    output BTk_t                  O_St_BTk,
    input  logic                  I_St_AccessEnd,
    input  logic                  I_St_Busy,
    input  logic                  I_Ld_Req,
    input  logic [WIDTH_ADDR-1:0] I_Ld_Addr,
    output BTk_t                  O_Ld_BTk,
    input  logic                  I_Ld_AccessEnd,
    input  logic                  I_Ld_Busy,
    output logic                  O_Ld_Valid,
    output logic [WIDTH_DATA-1:0] O_Ld_Data,
    output logic                  O_Mem_We,
    output logic                  O_Mem_Re,
    output logic [WIDTH_ADDR-1:0] O_Mem_Addr,
    output logic [WIDTH_DATA-1:0] O_Mem_Data,
    input  logic [WIDTH_DATA-1:0] I_Mem_Data,
    output logic [1:0]            O_Grant,
    output logic                  O_Busy
);

    cram_arb_state_t r_state;
    logic [1:0]      r_grant;
    logic            r_ld_vld;

    logic w_st_gnt;
    logic w_ld_gnt;
    logic w_st_end;
    logic w_ld_end;
    logic w_wd_inc;
    logic w_expire;
    logic w_pick_st;
    logic w_ld_vld;

    assign w_st_gnt = (r_state == GNT_ST);
    assign w_ld_gnt = (r_state == GNT_LD);
    assign w_st_end = w_st_gnt && (I_St_AccessEnd || I_St_FTk.r);
    assign w_ld_end = w_ld_gnt && I_Ld_AccessEnd;
    assign w_wd_inc = (w_st_gnt && !I_St_Req && !I_St_Busy) ||
                      (w_ld_gnt && !I_Ld_Req && !I_Ld_Busy);

    cram_arb_watchdog #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_watchdog (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_clr   (!w_wd_inc),
        .i_inc   (w_wd_inc),
        .o_expire(w_expire)
    );

`ifdef CRAM_ARB_FIXED_PRIO_EN
    assign w_pick_st = I_St_Req;
`else
    logic r_last_ld;

    assign w_pick_st = I_St_Req && (!I_Ld_Req || r_last_ld);

    // Remember the side granted last; only consulted again in IDLE, so
    // recording it at grant time equals recording the owner in DRAIN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last_ld <= 1'b1;
        end else if (r_state == IDLE && (I_St_Req || I_Ld_Req)) begin
            r_last_ld <= !w_pick_st;
        end
    end
`endif

    // Session FSM with registered grant and read-valid
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_ld_vld <= 1'b0;
        end else begin
            r_ld_vld <= w_ld_gnt && I_Ld_Req;
            case (r_state)
                IDLE: begin
                    if (I_St_Req || I_Ld_Req) begin
                        r_state <= w_pick_st ? GNT_ST : GNT_LD;
                        r_grant <= w_pick_st ? ARB_GNT_ST : ARB_GNT_LD;
                    end
                end
                GNT_ST: begin
                    if (w_st_end || w_expire) begin
                        r_state <= DRAIN;
                        r_grant <= '0;
                    end
                end
                GNT_LD: begin
                    if (w_ld_end || w_expire) begin
                        r_state <= DRAIN;
                        r_grant <= '0;
                    end
                end
                DRAIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Memory port steering and back-prop tokens, all forced low in reset
    always_comb begin
        O_Mem_We   = 1'b0;
        O_Mem_Re   = 1'b0;
        O_Mem_Addr = '0;
        O_Mem_Data = '0;
        O_St_BTk   = '0;
        O_Ld_BTk   = '0;
        if (!reset) begin
            if (w_st_gnt) begin
                O_Mem_We   = I_St_Req;
                O_Mem_Addr = I_St_Addr;
                O_Mem_Data = WIDTH_DATA'(I_St_FTk.d);
            end else if (w_ld_gnt) begin
                O_Mem_Re   = I_Ld_Req;
                O_Mem_Addr = I_Ld_Addr;
            end
            O_St_BTk.n = I_St_Req && !w_st_gnt;
            O_Ld_BTk.n = I_Ld_Req && !w_ld_gnt;
            O_St_BTk.t = w_st_end || (w_st_gnt && w_expire);
            O_Ld_BTk.t = w_ld_end || (w_ld_gnt && w_expire);
        end
    end

    // The macro registers its read data; qualify it with our registered valid
    assign w_ld_vld   = r_ld_vld && !reset;
    assign O_Ld_Valid = w_ld_vld;
    assign O_Ld_Data  = w_ld_vld ? I_Mem_Data : '0;
    assign O_Grant    = r_grant;
    assign O_Busy     = |r_grant;

endmodule

// File: tb/tb_cram_access_arb.sv
// Scoreboard bench for cram_access_arb: a session-level reference model
// predicts every cycle's outputs into a queue; a monitor pops and compares.
`timescale 1ns/1ps
module tb_cram_access_arb;
    import cram_access_arb_pkg::*;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        I_St_Req, I_St_AccessEnd, I_St_Busy;
    logic [7:0]  I_St_Addr;
    FTk_t        I_St_FTk;
    BTk_t        O_St_BTk, O_Ld_BTk;
    logic        I_Ld_Req, I_Ld_AccessEnd, I_Ld_Busy;
    logic [7:0]  I_Ld_Addr;
    logic        O_Ld_Valid, O_Mem_We, O_Mem_Re, O_Busy;
    logic [31:0] O_Ld_Data, O_Mem_Data, I_Mem_Data;
    logic [7:0]  O_Mem_Addr;
    logic [1:0]  O_Grant;

    always #5 clock = ~clock;

    cram_access_arb #(
        .WIDTH_DATA(32), .WIDTH_ADDR(8), .IDLE_TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .I_St_Req(I_St_Req), .I_St_Addr(I_St_Addr), .I_St_FTk(I_St_FTk),
        .O_St_BTk(O_St_BTk), .I_St_AccessEnd(I_St_AccessEnd), .I_St_Busy(I_St_Busy),
        .I_Ld_Req(I_Ld_Req), .I_Ld_Addr(I_Ld_Addr), .O_Ld_BTk(O_Ld_BTk),
        .I_Ld_AccessEnd(I_Ld_AccessEnd), .I_Ld_Busy(I_Ld_Busy),
        .O_Ld_Valid(O_Ld_Valid), .O_Ld_Data(O_Ld_Data),
        .O_Mem_We(O_Mem_We), .O_Mem_Re(O_Mem_Re), .O_Mem_Addr(O_Mem_Addr),
        .O_Mem_Data(O_Mem_Data), .I_Mem_Data(I_Mem_Data),
        .O_Grant(O_Grant), .O_Busy(O_Busy)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return (a == 8'h20) ? 32'h55 : {4{a ^ 8'hC3}};
    endfunction

    // CRAM macro stand-in with 1-cycle read latency
    logic [31:0]  ram [256];
    logic [255:0] ram_wr = '0;
    logic [31:0]  mem_q  = '0;
    always @(posedge clock) begin
        if (O_Mem_We) begin
            ram[O_Mem_Addr]    <= O_Mem_Data;
            ram_wr[O_Mem_Addr] <= 1'b1;
        end
        if (O_Mem_Re)
            mem_q <= ram_wr[O_Mem_Addr] ? ram[O_Mem_Addr] : init_val(O_Mem_Addr);
    end
    assign I_Mem_Data = mem_q;

    typedef struct {
        bit rst; bit st_req; logic [7:0] st_addr; logic [31:0] st_d;
        bit st_r; bit st_aend; bit st_busy;
        bit ld_req; logic [7:0] ld_addr; bit ld_aend; bit ld_busy;
    } stim_t;

    typedef struct {
        bit chk; logic [1:0] grant; logic busy;
        logic st_n; logic st_t; logic ld_n; logic ld_t;
        logic we; logic re; logic [7:0] addr; logic [31:0] wdata;
        logic vld; logic [31:0] rdata;
    } exp_t;

    stim_t s;
    exp_t  q[$];
    exp_t  me;
    int    checks = 0;
    int    errors = 0;
    bit    checks_on = 1'b1;

    // Reference model: session owner (0 none, 1 store, 2 load), drain flag,
    // last served side, idle count, pending read, and its own memory image.
    int          own = 0, last = 2, icnt = 0, dron = 0;
    bit          drn = 1'b0, rdp = 1'b0;
    logic [31:0] rdv = '0;
    logic [31:0] mmem [256];

    task automatic clr();
        s = '{default: '0};
    endtask

    task automatic step();
        exp_t e;
        bit   idle, expd, fin;
        int   win;
        @(negedge clock);
        reset          = s.rst;
        I_St_Req       = s.st_req;
        I_St_Addr      = s.st_addr;
        I_St_FTk.r     = s.st_r;
        I_St_FTk.d     = s.st_d;
        I_St_AccessEnd = s.st_aend;
        I_St_Busy      = s.st_busy;
        I_Ld_Req       = s.ld_req;
        I_Ld_Addr      = s.ld_addr;
        I_Ld_AccessEnd = s.ld_aend;
        I_Ld_Busy      = s.ld_busy;

        e = '{default: '0};
        e.chk   = checks_on;
        e.grant = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
        e.busy  = (own != 0);
        if (s.rst) begin
            own = 0; drn = 1'b0; last = 2; icnt = 0; rdp = 1'b0;
        end else begin
            e.vld   = rdp;
            e.rdata = rdp ? rdv : 32'h0;
            rdp     = 1'b0;
            e.st_n  = s.st_req && (own != 1);
            e.ld_n  = s.ld_req && (own != 2);
            if (drn) begin
                last = dron;
                drn  = 1'b0;
            end else if (own == 1) begin
                e.we = s.st_req; e.addr = s.st_addr; e.wdata = s.st_d;
                if (s.st_req) mmem[s.st_addr] = s.st_d;
                idle = !s.st_req && !s.st_busy;
                expd = idle && (icnt == TO - 1);
                icnt = idle ? icnt + 1 : 0;
                fin  = s.st_aend || s.st_r || expd;
                e.st_t = fin;
                if (fin) begin drn = 1'b1; dron = 1; own = 0; icnt = 0; end
            end else if (own == 2) begin
                e.re = s.ld_req; e.addr = s.ld_addr;
                if (s.ld_req) begin rdp = 1'b1; rdv = mmem[s.ld_addr]; end
                idle = !s.ld_req && !s.ld_busy;
                expd = idle && (icnt == TO - 1);
                icnt = idle ? icnt + 1 : 0;
                fin  = s.ld_aend || expd;
                e.ld_t = fin;
                if (fin) begin drn = 1'b1; dron = 2; own = 0; icnt = 0; end
            end else if (s.st_req || s.ld_req) begin
`ifdef CRAM_ARB_FIXED_PRIO_EN
                win = s.st_req ? 1 : 2;
`else
                if (s.st_req && s.ld_req) win = (last == 1) ? 2 : 1;
                else                      win = s.st_req ? 1 : 2;
`endif
                own  = win;
                icnt = 0;
            end
        end
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one expected record per cycle, sampled after inputs settle
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (q.size() == 0) begin
                if (O_Mem_We || O_Mem_Re || O_Ld_Valid)
                    chk("unexpected_activity", 64'({O_Mem_We, O_Mem_Re, O_Ld_Valid}), 64'd0);
            end else begin
                me = q.pop_front();
                if (me.chk) begin
                    chk("grant",  64'(O_Grant),  64'(me.grant));
                    chk("busy",   64'(O_Busy),   64'(me.busy));
                    chk("st_btk", 64'(O_St_BTk), 64'({1'b0, me.st_t, me.st_n}));
                    chk("ld_btk", 64'(O_Ld_BTk), 64'({1'b0, me.ld_t, me.ld_n}));
                    chk("mem_we", 64'(O_Mem_We), 64'(me.we));
                    chk("mem_re", 64'(O_Mem_Re), 64'(me.re));
                    chk("we_re_excl", 64'(O_Mem_We & O_Mem_Re), 64'd0);
                    chk("mem_addr", 64'(O_Mem_Addr), 64'(me.addr));
                    chk("mem_wdata", 64'(O_Mem_Data), 64'(me.wdata));
                    chk("ld_valid", 64'(O_Ld_Valid), 64'(me.vld));
                    chk("ld_data",  64'(O_Ld_Data),  64'(me.rdata));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mmem[i] = init_val(8'(i));
        clr();

        // reset; first cycle only establishes state
        s.rst = 1'b1; checks_on = 1'b0; step(); checks_on = 1'b1; step(); step();
        clr(); step(); step();

        // store block 0x10..0x13 / 0xA0..0xA3, end on 4th word
        s.st_req = 1'b1; s.st_addr = 8'h10; s.st_d = 32'hA0; step();
        for (int i = 0; i < 4; i++) begin
            s.st_addr = 8'(8'h10 + i); s.st_d = 32'(32'hA0 + i);
            s.st_aend = (i == 3); step();
        end
        clr(); repeat (3) step();

        // single load from 0x20 (holds 0x55)
        s.ld_req = 1'b1; s.ld_addr = 8'h20; step();
        s.ld_aend = 1'b1; step();
        clr(); repeat (3) step();

        // tie: store first, load held off, then load, then tie again
        s.st_req = 1'b1; s.ld_req = 1'b1; s.ld_addr = 8'h11;
        s.st_addr = 8'h30; s.st_d = 32'h1; step();
        for (int i = 0; i < 3; i++) begin
            s.st_addr = 8'(8'h30 + i); s.st_d = 32'(32'h100 + i);
            s.st_aend = (i == 2); step();
        end
        s.st_req = 1'b0; s.st_aend = 1'b0; repeat (2) step();
        for (int i = 0; i < 2; i++) begin
            s.ld_addr = 8'(8'h30 + i); s.ld_aend = (i == 1); step();
        end
        s.ld_aend = 1'b0; s.st_req = 1'b1; s.st_addr = 8'h40; s.st_d = 32'hBEEF;
        repeat (2) step();
        s.st_aend = 1'b1; s.ld_aend = 1'b1; repeat (4) step();
        clr(); repeat (3) step();

        // watchdog: idle gaps, one request restarts the count, then expiry
        s.st_req = 1'b1; s.st_addr = 8'h50; s.st_d = 32'h9; step();
        s.st_req = 1'b0; repeat (2) step();
        s.st_req = 1'b1; step();
        s.st_req = 1'b0; repeat (7) step();
        s.ld_req = 1'b1; s.ld_addr = 8'h50; step();
        s.ld_req = 1'b0; s.ld_busy = 1'b1; repeat (3) step();
        s.ld_busy = 1'b0; repeat (6) step();

        // reset during a load session with a read outstanding
        clr(); s.ld_req = 1'b1; s.ld_addr = 8'h20; step(); step();
        s.rst = 1'b1; step();
        clr(); s.st_req = 1'b1; s.ld_req = 1'b1; s.st_addr = 8'h60; s.st_d = 32'h6; step();
        s.st_aend = 1'b1; step();
        clr(); repeat (3) step();

        // release via FTk.r, then read the word back
        s.st_req = 1'b1; s.st_addr = 8'h05; s.st_d = 32'h77; step();
        s.st_r = 1'b1; step();
        clr(); repeat (3) step();
        s.ld_req = 1'b1; s.ld_addr = 8'h05; step();
        s.ld_aend = 1'b1; step();
        clr(); repeat (3) step();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            s.rst     = ($urandom_range(0, 199) == 0);
            s.st_req  = ($urandom_range(0, 1) == 1);
            s.st_addr = 8'($urandom_range(0, 15));
            s.st_d    = $urandom();
            s.st_aend = ($urandom_range(0, 9) == 0);
            s.st_r    = ($urandom_range(0, 19) == 0);
            s.st_busy = ($urandom_range(0, 2) == 0);
            s.ld_req  = ($urandom_range(0, 1) == 1);
            s.ld_addr = 8'($urandom_range(0, 15));
            s.ld_aend = ($urandom_range(0, 9) == 0);
            s.ld_busy = ($urandom_range(0, 2) == 0);
            step();
        end
        clr(); repeat (8) step();

        @(posedge clock);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
